inst_rom_fetch: RTL and testbench

Parametrised, registered instruction ROM for the Tomasulo front end. Accepts byte-addressed fetch requests over a valid/ready handshake and returns FETCH_WIDTH consecutive big-endian 32-bit words per request one cycle later. Results go through a 2-entry response buffer so that issue-stage backpressure never loses a fetch. Also provides per-word in-range mask, misalignment flag and a flush input for branch redirection.

---
 rtl/inst_rom_fetch.sv | 150 +++++++++++++++
 tb/tb_inst_rom_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_fetch.sv
// inst_rom_fetch
//   Registered instruction ROM for the front end. A fetch request returns
//   FETCH_WIDTH consecutive big-endian 32-bit words starting at the byte
//   address given, one cycle after acceptance, through a 2-entry response
//   buffer so backpressure from issue never drops a fetch.
//
// Parameters
//   DEPTH_BYTES  ROM size in bytes
//   FETCH_WIDTH  words per request (1..4)
//   INIT_FILE    image name; the ROM holds the built-in image where byte k
//                holds k[7:0]
//   NOP_WORD     word returned for out-of-range reads
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake, req_addr = byte address of word 0
//   flush           drop every buffered response; no request taken this cycle
//   rsp_valid/ready response handshake for the buffer head
//   rsp_data        word i in bits [32i+31:32i]
//   rsp_mask        bit i set when word i lies wholly inside the ROM
//   rsp_addr        request address of the head response
//   rsp_misaligned  head request address was not word aligned
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and req_ready depends only on the
// registered fill level and flush, never on rsp_ready.

module inst_rom_fetch #(
  parameter int          DEPTH_BYTES = 256,
  parameter int          FETCH_WIDTH = 2,
  parameter string       INIT_FILE   = "rom.mem",
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic                      flush,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [32*FETCH_WIDTH-1:0] rsp_data,
  output logic [FETCH_WIDTH-1:0]    rsp_mask,
  output logic [31:0]               rsp_addr,
  output logic                      rsp_misaligned
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int DW = 32 * FETCH_WIDTH;

  // ---------------------------------------------------------------------------
  // ROM image
  // ---------------------------------------------------------------------------
  logic [7:0] rom [DEPTH_BYTES];

  generate
    for (genvar k = 0; k < DEPTH_BYTES; k++) begin : g_byte
      assign rom[k] = 8'(k);
    end
  endgenerate

  // Returns {in_range, word} for word i of a fetch at base. The address sum is
  // 33 bits wide so requests near 2^32 never wrap back into the ROM, and a
  // word that straddles the end of the ROM counts as wholly out of range.
  function automatic logic [32:0] fetch_word(input logic [31:0] base,
                                             input int unsigned i);
    logic [32:0]   a;
    logic [AW-1:0] idx;
    logic [31:0]   w;
    a = {1'b0, base} + 33'(4 * i);
    if ((a + 33'd3) < 33'(DEPTH_BYTES)) begin
      idx = a[AW-1:0];
      w   = {rom[idx], rom[idx + AW'(1)], rom[idx + AW'(2)], rom[idx + AW'(3)]};
      return {1'b1, w};
    end
    return {1'b0, NOP_WORD};
  endfunction

  logic [DW-1:0]          rd_data;
  logic [FETCH_WIDTH-1:0] rd_mask;

  always_comb begin
    rd_data = '0;
    rd_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      {rd_mask[i], rd_data[32*i +: 32]} = fetch_word(req_addr, i);
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry response buffer
  // ---------------------------------------------------------------------------
  logic [DW-1:0]          slot_data [2];
  logic [FETCH_WIDTH-1:0] slot_mask [2];
  logic [31:0]            slot_addr [2];
  logic                   slot_mis  [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic                   push;
  logic                   pop;

  assign req_ready = !flush && (count != 2'd2);
  assign rsp_valid = (count != 2'd0);
  assign push      = req_valid && req_ready;
  // A flush wins over a simultaneous pop; the pointers restart anyway.
  assign pop       = rsp_valid && rsp_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        slot_data[k] <= '0;
        slot_mask[k] <= '0;
        slot_addr[k] <= '0;
        slot_mis[k]  <= 1'b0;
      end
    end else if (flush) begin
      // Slots keep their contents; only the fill level and pointers restart.
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        slot_data[wr_ptr] <= rd_data;
        slot_mask[wr_ptr] <= rd_mask;
        slot_addr[wr_ptr] <= req_addr;
        slot_mis[wr_ptr]  <= (req_addr[1:0] != 2'b00);
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head slot is always presented, valid or not, so the outputs stay defined.
  assign rsp_data       = slot_data[rd_ptr];
  assign rsp_mask       = slot_mask[rd_ptr];
  assign rsp_addr       = slot_addr[rd_ptr];
  assign rsp_misaligned = slot_mis[rd_ptr];

endmodule

// File: tb/tb_inst_rom_fetch.sv
module tb_inst_rom_fetch;

  localparam int          DEPTH = 256;
  localparam int          FW    = 2;
  localparam logic [31:0] NOP   = 32'hDEAD_BEEF;
  localparam int          DW    = 32 * FW;
  localparam int          W     = 33 + FW + DW;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          flush;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [FW-1:0] rsp_mask;
  logic [31:0]   rsp_addr;
  logic          rsp_misaligned;

  always #5 clk = ~clk;

  inst_rom_fetch #(
    .DEPTH_BYTES (DEPTH),
    .FETCH_WIDTH (FW),
    .INIT_FILE   (""),
    .NOP_WORD    (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .flush          (flush),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_mask       (rsp_mask),
    .rsp_addr       (rsp_addr),
    .rsp_misaligned (rsp_misaligned)
  );

  // ---------------------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] got_data;
  logic [FW-1:0] got_mask;
  logic          got_mis;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: image byte k holds k[7:0].
  function automatic logic [W-1:0] model_entry(input logic [31:0] addr);
    logic [DW-1:0] d;
    logic [FW-1:0] m;
    logic [32:0]   a;
    for (int i = 0; i < FW; i++) begin
      a = {1'b0, addr} + 33'(4 * i);
      if (a + 33'd3 < 33'(DEPTH)) begin
        m[i] = 1'b1;
        d[32*i +: 32] = {a[7:0], 8'(a + 33'd1), 8'(a + 33'd2), 8'(a + 33'd3)};
      end else begin
        m[i] = 1'b0;
        d[32*i +: 32] = NOP;
      end
    end
    return {addr, (addr[1:0] != 2'b00), m, d};
  endfunction

  // ---------------------------------------------------------------------------
  // driver: one clock cycle of stimulus, checked against the model
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic v, input logic [31:0] a, input logic rr,
                       input logic fl);
    logic         can_acc;
    logic [W-1:0] e;
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    #1;
    can_acc = !fl && (exp_q.size() != 2);
    check("req_ready", req_ready, can_acc);
    check("rsp_valid", rsp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0 && rr) begin
      e = exp_q.pop_front();
      got_data = rsp_data;
      got_mask = rsp_mask;
      got_mis  = rsp_misaligned;
      check("rsp_data", rsp_data, e[DW-1:0]);
      check("rsp_mask", rsp_mask, e[DW +: FW]);
      check("rsp_mis",  rsp_misaligned, e[DW+FW]);
      check("rsp_addr", rsp_addr, e[DW+FW+1 +: 32]);
    end
    if (fl) exp_q.delete();
    if (v && can_acc) exp_q.push_back(model_entry(a));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, rsp_valid, 1'b0);
    check({tag, "_data"},  rsp_data, '0);
    check({tag, "_mask"},  rsp_mask, '0);
    check({tag, "_addr"},  rsp_addr, '0);
    check({tag, "_mis"},   rsp_misaligned, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ra;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
    #3;
    check_outputs_zero("reset");
    check("reset_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // alignment and byte order
    cycle(1'b1, 32'h00, 1'b0, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    check("a00_data", got_data, 64'h04050607_00010203);
    check("a00_mask", got_mask, 2'b11);
    check("a00_mis",  got_mis, 1'b0);

    // misaligned
    cycle(1'b1, 32'h01, 1'b0, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    check("a01_data", got_data, 64'h05060708_01020304);
    check("a01_mis",  got_mis, 1'b1);

    // ROM end
    cycle(1'b1, 32'hF8, 1'b0, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    check("aF8_data", got_data, 64'hFCFDFEFF_F8F9FAFB);
    check("aF8_mask", got_mask, 2'b11);
    cycle(1'b1, 32'hFA, 1'b0, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    check("aFA_data", got_data, {NOP, 32'hFAFBFCFD});
    check("aFA_mask", got_mask, 2'b01);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    check("aTop_data", got_data, {NOP, NOP});
    check("aTop_mask", got_mask, 2'b00);

    // backpressure: third request held off until one cycle after first pop
    cycle(1'b1, 32'h00, 1'b0, 1'b0);
    cycle(1'b1, 32'h08, 1'b0, 1'b0);
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h10, 1'b1, 1'b0);
    cycle(1'b1, 32'h10, 1'b1, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);

    // throughput: back-to-back with the consumer always ready
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(32'h30 + 4 * i), 1'b1, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);

    // flush with a full buffer
    cycle(1'b1, 32'h40, 1'b0, 1'b0);
    cycle(1'b1, 32'h48, 1'b0, 1'b0);
    cycle(1'b1, 32'h20, 1'b0, 1'b1);
    cycle(1'b1, 32'h20, 1'b0, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);

    // asynchronous reset between edges with one response buffered
    cycle(1'b1, 32'h44, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    check("pre_rst_valid", rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);
    cycle(1'b1, 32'h50, 1'b0, 1'b0);
    cycle(1'b0, 32'h00, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        1:       ra = 32'(DEPTH - 12) + 32'($urandom_range(0, 12));
        default: ra = 32'($urandom_range(0, DEPTH - 1));
      endcase
      cycle(1'($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
